pong_game_controller: RTL



---
 rtl/pong_game_controller.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_game_controller.sv
// Pong match sequencer: ball motion, paddle control, scoring and serve/game-over flow.
// Everything advances on frame_tick. Results appear one CLK_IN cycle later.
//   state     | meaning
//   IDLE      | ball parked at centre, waiting for start
//   PLAY      | ball and computer paddle moving, misses scored
//   SCORED    | ball frozen at centre for SERVE_DELAY ticks before re-serve
//   GAME_OVER | a side reached WIN_SCORE, everything frozen until start
module pong_game_controller #(
   parameter int W            = 160,
   parameter int H            = 120,
   parameter int BLOCK        = 4,
   parameter int PADDLE_LEN   = 32,
   parameter int PLAYER_X     = 4,
   parameter int COM_X        = 155,
   parameter int BALL_SPEED   = 1,
   parameter int PADDLE_SPEED = 2,
   parameter int COM_SPEED    = 1,
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_DELAY  = 60
) (
   input  logic       CLK_IN,
   input  logic       RESET,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [7:0] ballX,
   output logic [6:0] ballY,
   output logic [6:0] playerYPos,
   output logic [6:0] comYPos,
   output logic [3:0] playerScore,
   output logic [3:0] comScore,
   output logic [1:0] game_state,
   output logic       game_over
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_SCORED = 2'd2,
      ST_OVER   = 2'd3
   } state_t;

   localparam int CW = $clog2(SERVE_DELAY + 1);

   localparam logic [9:0] BALL_X0    = 10'((W - BLOCK) / 2);
   localparam logic [9:0] BALL_Y0    = 10'((H - BLOCK) / 2);
   localparam logic [9:0] PAD_Y0     = 10'((H - PADDLE_LEN) / 2);
   localparam logic [9:0] PAD_MAX    = 10'(H - PADDLE_LEN);
   localparam logic [9:0] BALL_Y_MAX = 10'(H - BLOCK);
   localparam logic [9:0] BS         = 10'(BALL_SPEED);
   localparam logic [9:0] PS         = 10'(PADDLE_SPEED);
   localparam logic [9:0] CS         = 10'(COM_SPEED);
   localparam logic [9:0] BLK        = 10'(BLOCK);
   localparam logic [9:0] PLEN       = 10'(PADDLE_LEN);
   localparam logic [9:0] HALF_B     = 10'(BLOCK / 2);
   localparam logic [9:0] HALF_P     = 10'(PADDLE_LEN / 2);
   localparam logic [9:0] LEFT_LIM   = 10'(PLAYER_X + BALL_SPEED);
   localparam logic [9:0] LEFT_RET   = 10'(PLAYER_X + 1);
   localparam logic [9:0] RIGHT_EDGE = 10'(COM_X);
   localparam logic [9:0] RIGHT_RET  = 10'(COM_X - BLOCK);
   localparam logic [3:0] WIN        = 4'(WIN_SCORE);
   localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY - 1);

   state_t          state_q, state_d;
   logic [7:0]      ball_x_q, ball_x_d;
   logic [6:0]      ball_y_q, ball_y_d;
   logic [6:0]      player_y_q, player_y_d;
   logic [6:0]      com_y_q, com_y_d;
   logic [3:0]      player_score_q, player_score_d;
   logic [3:0]      com_score_q, com_score_d;
   logic            dx_q, dx_d;   // 1 = moving right
   logic            dy_q, dy_d;   // 1 = moving down
   logic [CW-1:0]   serve_cnt_q, serve_cnt_d;
   logic            game_over_q, game_over_d;
   logic            miss_left, miss_right;

   logic [9:0] bx, by, py, cy;
   assign bx = {2'b00, ball_x_q};
   assign by = {3'b000, ball_y_q};
   assign py = {3'b000, player_y_q};
   assign cy = {3'b000, com_y_q};

   function automatic logic [6:0] step_up(input logic [9:0] pos, input logic [9:0] amt);
      return (pos <= amt) ? 7'd0 : 7'(pos - amt);
   endfunction

   function automatic logic [6:0] step_down(input logic [9:0] pos, input logic [9:0] amt);
      return (pos + amt >= PAD_MAX) ? 7'(PAD_MAX) : 7'(pos + amt);
   endfunction

   // Strict on both sides: a ball only touching the paddle end is a miss.
   function automatic logic overlap(input logic [9:0] ball_y, input logic [9:0] pad_y);
      return (ball_y + BLK > pad_y) && (ball_y < pad_y + PLEN);
   endfunction

   always_comb begin
      state_d        = state_q;
      ball_x_d       = ball_x_q;
      ball_y_d       = ball_y_q;
      player_y_d     = player_y_q;
      com_y_d        = com_y_q;
      player_score_d = player_score_q;
      com_score_d    = com_score_q;
      dx_d           = dx_q;
      dy_d           = dy_q;
      serve_cnt_d    = serve_cnt_q;
      game_over_d    = game_over_q;
      miss_left      = 1'b0;
      miss_right     = 1'b0;

      if (frame_tick) begin
         if (state_q != ST_OVER) begin
            if (btn_up && !btn_down)
               player_y_d = step_up(py, PS);
            else if (btn_down && !btn_up)
               player_y_d = step_down(py, PS);
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_PLAY;
                  dx_d    = 1'b1;
                  dy_d    = 1'b1;
               end
            end

            ST_PLAY: begin
               if (by + HALF_B < cy + HALF_P)
                  com_y_d = step_up(cy, CS);
               else if (by + HALF_B > cy + HALF_P)
                  com_y_d = step_down(cy, CS);

               if (dy_q) begin
                  if (by + BS >= BALL_Y_MAX) begin
                     ball_y_d = 7'(BALL_Y_MAX);
                     dy_d     = 1'b0;
                  end else begin
                     ball_y_d = 7'(by + BS);
                  end
               end else if (by <= BS) begin
                  ball_y_d = 7'd0;
                  dy_d     = 1'b1;
               end else begin
                  ball_y_d = 7'(by - BS);
               end

               // Edge checks follow the travel direction so a freshly returned ball is not re-hit.
               if (!dx_q) begin
                  if (bx <= LEFT_LIM) begin
                     if (overlap(by, py)) begin
                        ball_x_d = 8'(LEFT_RET);
                        dx_d     = 1'b1;
                     end else begin
                        miss_left = 1'b1;
                     end
                  end else begin
                     ball_x_d = 8'(bx - BS);
                  end
               end else begin
                  if (bx + BLK + BS >= RIGHT_EDGE) begin
                     if (overlap(by, cy)) begin
                        ball_x_d = 8'(RIGHT_RET);
                        dx_d     = 1'b0;
                     end else begin
                        miss_right = 1'b1;
                     end
                  end else begin
                     ball_x_d = 8'(bx + BS);
                  end
               end

               if (miss_left || miss_right) begin
                  ball_x_d    = 8'(BALL_X0);
                  ball_y_d    = 7'(BALL_Y0);
                  dy_d        = 1'b1;
                  dx_d        = miss_right;
                  serve_cnt_d = '0;
                  if (miss_left)
                     com_score_d = com_score_q + 4'd1;
                  else
                     player_score_d = player_score_q + 4'd1;
                  if (com_score_d == WIN || player_score_d == WIN) begin
                     state_d     = ST_OVER;
                     game_over_d = 1'b1;
                  end else begin
                     state_d = ST_SCORED;
                  end
               end
            end

            ST_SCORED: begin
               if (serve_cnt_q == SERVE_LAST) begin
                  state_d     = ST_PLAY;
                  serve_cnt_d = '0;
               end else begin
                  serve_cnt_d = serve_cnt_q + CW'(1);
               end
            end

            ST_OVER: begin
               if (start) begin
                  state_d        = ST_PLAY;
                  game_over_d    = 1'b0;
                  player_score_d = 4'd0;
                  com_score_d    = 4'd0;
                  ball_x_d       = 8'(BALL_X0);
                  ball_y_d       = 7'(BALL_Y0);
                  player_y_d     = 7'(PAD_Y0);
                  com_y_d        = 7'(PAD_Y0);
                  dx_d           = 1'b1;
                  dy_d           = 1'b1;
               end
            end

            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK_IN or posedge RESET) begin
      if (RESET) begin
         state_q        <= ST_IDLE;
         ball_x_q       <= 8'(BALL_X0);
         ball_y_q       <= 7'(BALL_Y0);
         player_y_q     <= 7'(PAD_Y0);
         com_y_q        <= 7'(PAD_Y0);
         player_score_q <= 4'd0;
         com_score_q    <= 4'd0;
         dx_q           <= 1'b1;
         dy_q           <= 1'b1;
         serve_cnt_q    <= '0;
         game_over_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         ball_x_q       <= ball_x_d;
         ball_y_q       <= ball_y_d;
         player_y_q     <= player_y_d;
         com_y_q        <= com_y_d;
         player_score_q <= player_score_d;
         com_score_q    <= com_score_d;
         dx_q           <= dx_d;
         dy_q           <= dy_d;
         serve_cnt_q    <= serve_cnt_d;
         game_over_q    <= game_over_d;
      end
   end

   assign ballX       = ball_x_q;
   assign ballY       = ball_y_q;
   assign playerYPos  = player_y_q;
   assign comYPos     = com_y_q;
   assign playerScore = player_score_q;
   assign comScore    = com_score_q;
   assign game_state  = state_q;
   assign game_over   = game_over_q;

endmodule
